// File: rtl/video_timing_pkg.sv
// Shared timing constants, output bundle and lock FSM encoding for the raster generator.
package video_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_HSYNC_POL = 1'b0;
    localparam bit VGA_VSYNC_POL = 1'b0;
    localparam int VGA_LOCK_SETTLE = 1024;

    localparam int CNT_W     = 10;
    localparam int CNT_RANGE = 1 << CNT_W;

    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN
    } lock_state_e;

    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             active;
        logic             new_line;
        logic             new_frame;
        logic             vblank;
        logic             running;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } vid_out_t;

    function automatic vid_out_t idle_outputs(input logic hpol, input logic vpol);
        vid_out_t o;
        o        = '0;
        o.hsync  = ~hpol;
        o.vsync  = ~vpol;
        o.vblank = 1'b1;
        return o;
    endfunction

endpackage

// File: rtl/video_timing_gen_lock_qualifier.sv
// Synchronises pll_locked and asserts run_en once lock has been stable for LOCK_SETTLE cycles.
module lock_qualifier
    import video_timing_pkg::*;
#(
    parameter int LOCK_SETTLE = VGA_LOCK_SETTLE
) (
    input  logic clock,
    input  logic reset,
    input  logic pll_locked,
    output logic run_en
);

    localparam int SW = $clog2(LOCK_SETTLE);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

    logic [1:0]    sync_q;
    logic          lock_s;
    lock_state_e   state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;

    assign lock_s = sync_q[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], pll_locked};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The IDLE cycle that first sees lock counts as lock cycle one of the settle run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (lock_s) begin
                    state_d = SETTLE;
                    cnt_d   = SW'(1);
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        run_en = (state_q == RUN);
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with registered syncs, active qualifier and coordinates.
// Define VIDEO_TIMING_LOCK_GATE_EN to hold the raster idle until pll_locked has settled.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter bit HSYNC_POL   = VGA_HSYNC_POL,
    parameter bit VSYNC_POL   = VGA_VSYNC_POL,
    parameter int LOCK_SETTLE = VGA_LOCK_SETTLE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       new_line,
    output logic       new_frame,
    output logic       vblank,
    output logic       running
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > CNT_RANGE || V_TOTAL > CNT_RANGE) begin : g_bad_totals
            $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
        end
        if (LOCK_SETTLE < 2) begin : g_bad_settle
            $error("video_timing_gen: LOCK_SETTLE must be at least 2");
        end
    endgenerate

    // Boundaries are one bit wider than the counters so H_TOTAL==1024 cannot wrap.
    localparam logic [CNT_W:0]   H_ACT_END = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   HS_START  = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   HS_END    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   V_ACT_END = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0]   VS_START  = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   VS_END    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam vid_out_t         IDLE_OUT  = idle_outputs(HSYNC_POL, VSYNC_POL);

    logic             run_en;
    logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [CNT_W:0]   hc_x, vc_x;
    vid_out_t         out_q, out_d;

`ifdef VIDEO_TIMING_LOCK_GATE_EN
    lock_qualifier #(
        .LOCK_SETTLE (LOCK_SETTLE)
    ) u_lock_qualifier (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .run_en     (run_en)
    );
`else
    logic unused_pll_locked;
    assign unused_pll_locked = pll_locked;
    assign run_en            = 1'b1;
`endif

    assign hc_x = {1'b0, hc_q};
    assign vc_x = {1'b0, vc_q};

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        hc_d  = '0;
        vc_d  = '0;
        out_d = IDLE_OUT;
        if (run_en) begin
            out_d.running   = 1'b1;
            out_d.x         = hc_q;
            out_d.y         = vc_q;
            out_d.active    = (hc_x < H_ACT_END) && (vc_x < V_ACT_END);
            out_d.hsync     = (hc_x >= HS_START && hc_x < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            out_d.vsync     = (vc_x >= VS_START && vc_x < VS_END) ? VSYNC_POL : ~VSYNC_POL;
            out_d.new_line  = (hc_q == '0);
            out_d.new_frame = (hc_q == '0) && (vc_q == '0);
            out_d.vblank    = (vc_x >= V_ACT_END);
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
            end else begin
                hc_d = hc_q + CNT_W'(1);
                vc_d = vc_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            hc_q  <= '0;
            vc_q  <= '0;
            out_q <= IDLE_OUT;
        end else begin
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            out_q <= out_d;
        end
    end

    assign hsync     = out_q.hsync;
    assign vsync     = out_q.vsync;
    assign active    = out_q.active;
    assign x         = out_q.x;
    assign y         = out_q.y;
    assign new_line  = out_q.new_line;
    assign new_frame = out_q.new_frame;
    assign vblank    = out_q.vblank;
    assign running   = out_q.running;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a small raster so whole frames fit in the run.
`timescale 1ns/1ps
module tb_video_timing_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = 32;
    localparam int VT = 19;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;
    localparam int LS = 1024;
`ifdef VIDEO_TIMING_LOCK_GATE_EN
    localparam bit GATED     = 1'b1;
    localparam int START_LAT = 2 + LS + 1;
`else
    localparam bit GATED     = 1'b0;
    localparam int START_LAT = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       hsync, vsync, active, new_line, new_frame, vblank, running;
    logic [9:0] x, y;

    always #5 clock = ~clock;

    video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HSYNC_POL (HPOL), .VSYNC_POL (VPOL), .LOCK_SETTLE (LS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .hsync      (hsync),
        .vsync      (vsync),
        .active     (active),
        .x          (x),
        .y          (y),
        .new_line   (new_line),
        .new_frame  (new_frame),
        .vblank     (vblank),
        .running    (running)
    );

    typedef struct packed {
        logic       running;
        logic       hsync;
        logic       vsync;
        logic       active;
        logic       new_line;
        logic       new_frame;
        logic       vblank;
        logic [9:0] x;
        logic [9:0] y;
    } vout_t;

    typedef struct {
        int    n;
        vout_t exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vout_t cur_out();
        return {running, hsync, vsync, active, new_line, new_frame, vblank, x, y};
    endfunction

    function automatic vout_t idle_out();
        vout_t v;
        v        = '0;
        v.hsync  = !HPOL;
        v.vsync  = !VPOL;
        v.vblank = 1'b1;
        return v;
    endfunction

    // Expected outputs after n raster cycles, straight from the counter arithmetic.
    function automatic vout_t ref_out(input bit run, input int unsigned n);
        vout_t       v;
        int unsigned hc, vc;
        v = idle_out();
        if (run) begin
            hc          = n % HT;
            vc          = (n / HT) % VT;
            v.running   = 1'b1;
            v.x         = 10'(hc);
            v.y         = 10'(vc);
            v.active    = (hc < HA) && (vc < VA);
            v.hsync     = (hc >= HA + HF && hc < HA + HF + HS) ? HPOL : !HPOL;
            v.vsync     = (vc >= VA + VF && vc < VA + VF + VS) ? VPOL : !VPOL;
            v.new_line  = (hc == 0);
            v.new_frame = (hc == 0) && (vc == 0);
            v.vblank    = (vc >= VA);
        end
        return v;
    endfunction

    function automatic vout_t mk(input int vx, input int vy, input bit hs, input bit vs,
                                 input bit act, input bit vb, input bit nl, input bit nf);
        vout_t v;
        v.running = 1'b1; v.x = 10'(vx); v.y = 10'(vy);
        v.hsync = hs; v.vsync = vs; v.active = act; v.vblank = vb;
        v.new_line = nl; v.new_frame = nf;
        return v;
    endfunction

    // Reference model: lock history as a queue of pin samples and a consecutive-lock run length.
    bit          pin_h[$];
    int unsigned consec  = 0;
    bit          run_st  = 1'b0;
    int unsigned run_n   = 0;
    bit          model_on = 1'b1;

    task automatic step();
        vout_t exp;
        bit    s;
        @(posedge clock);
        #1;
        exp = reset ? idle_out() : ref_out(run_st, run_n);
        if (reset) begin
            pin_h.delete();
            consec = 0;
            run_st = !GATED;
            run_n  = 0;
        end else begin
            s = 1'b0;
            if (pin_h.size() == 2) s = pin_h.pop_front();
            pin_h.push_back(pll_locked);
            run_n = run_st ? run_n + 1 : 0;
            if (GATED) begin
                consec = s ? ((consec < LS) ? consec + 1 : consec) : 0;
                run_st = (consec >= LS);
            end else begin
                run_st = 1'b1;
            end
        end
        if (model_on) check("model", cur_out(), exp);
    endtask

    task automatic expect_start(input string name, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!running && lat < 4000);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_first"}, cur_out(), ref_out(1'b1, 0));
    endtask

    task automatic run_to(input int tx, input int ty);
        int k;
        k = 0;
        while (!(running && x == 10'(tx) && y == 10'(ty)) && k < 2000) begin
            step();
            k++;
        end
        check("run_to_reach", (k < 2000), 1);
    endtask

    vec_t vecs[15];

    initial begin
        int cur_n, nl_cnt, act_cnt, hs_cnt, vs_cnt, vb_cnt, nf_at, gap_err, last_nl, total, len, r;

        vecs[0]  = '{0,   mk(0,  0,  1, 0, 1, 0, 1, 1)};
        vecs[1]  = '{15,  mk(15, 0,  1, 0, 1, 0, 0, 0)};
        vecs[2]  = '{16,  mk(16, 0,  1, 0, 0, 0, 0, 0)};
        vecs[3]  = '{19,  mk(19, 0,  1, 0, 0, 0, 0, 0)};
        vecs[4]  = '{20,  mk(20, 0,  0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{25,  mk(25, 0,  0, 0, 0, 0, 0, 0)};
        vecs[6]  = '{26,  mk(26, 0,  1, 0, 0, 0, 0, 0)};
        vecs[7]  = '{32,  mk(0,  1,  1, 0, 1, 0, 1, 0)};
        vecs[8]  = '{357, mk(5,  11, 1, 0, 1, 0, 0, 0)};
        vecs[9]  = '{384, mk(0,  12, 1, 0, 0, 1, 1, 0)};
        vecs[10] = '{448, mk(0,  14, 1, 1, 0, 1, 1, 0)};
        vecs[11] = '{511, mk(31, 15, 1, 1, 0, 1, 0, 0)};
        vecs[12] = '{512, mk(0,  16, 1, 0, 0, 1, 1, 0)};
        vecs[13] = '{607, mk(31, 18, 1, 0, 0, 1, 0, 0)};
        vecs[14] = '{608, mk(0,  0,  1, 0, 1, 0, 1, 1)};

        reset      = 1'b1;
        pll_locked = 1'b0;
        repeat (3) step();
        check("reset_idle", cur_out(), idle_out());

        reset      = 1'b0;
        pll_locked = 1'b1;
        expect_start("startup", START_LAT);

        cur_n = 0;
        foreach (vecs[i]) begin
            while (cur_n < vecs[i].n) begin
                step();
                cur_n++;
            end
            check($sformatf("vec_n%0d", vecs[i].n), cur_out(), vecs[i].exp);
        end

        nl_cnt = 0; act_cnt = 0; hs_cnt = 0; vs_cnt = 0; vb_cnt = 0;
        nf_at = -1; gap_err = 0; last_nl = 0;
        for (int k = 1; k <= HT * VT; k++) begin
            step();
            if (new_line) begin
                nl_cnt++;
                if (k - last_nl != HT && last_nl != 0) gap_err++;
                last_nl = k;
            end
            if (new_frame && nf_at < 0) nf_at = k;
            if (active) act_cnt++;
            if (hsync == HPOL) hs_cnt++;
            if (vsync == VPOL) vs_cnt++;
            if (vblank) vb_cnt++;
        end
        check("frame_period", nf_at, HT * VT);
        check("lines_per_frame", nl_cnt, VT);
        check("line_gap_errors", gap_err, 0);
        check("active_per_frame", act_cnt, HA * VA);
        check("hsync_per_frame", hs_cnt, HS * VT);
        check("vsync_per_frame", vs_cnt, VS * HT);
        check("vblank_per_frame", vb_cnt, (VT - VA) * HT);

`ifdef VIDEO_TIMING_LOCK_GATE_EN
        run_to(3, 5);
        pll_locked = 1'b0;
        len = 0;
        do begin
            step();
            len++;
        end while (running && len < 20);
        check("loss_latency", len, 4);
        check("loss_idle", cur_out(), idle_out());

        pll_locked = 1'b1;
        expect_start("relock", START_LAT);

        pll_locked = 1'b0;
        repeat (8) step();
        pll_locked = 1'b1;
        repeat (500) step();
        check("settle_not_running", running, 1'b0);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        expect_start("glitch", START_LAT);
`else
        len = 0;
        for (int k = 0; k < 200; k++) begin
            pll_locked = k[0];
            step();
            if (!running) len++;
        end
        check("ungated_ignores_lock", len, 0);
        pll_locked = 1'b1;
`endif

        run_to(10, 5);
        reset = 1'b1;
        step();
        check("midreset_idle", cur_out(), idle_out());
        reset = 1'b0;
        expect_start("post_reset", START_LAT);

        total = 0;
        while (total < 16000) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                reset = 1'b1;
                len   = int'($urandom_range(1, 3));
            end else if (r < 40) begin
                reset      = 1'b0;
                pll_locked = 1'b0;
                len        = int'($urandom_range(1, 40));
            end else begin
                reset      = 1'b0;
                pll_locked = 1'b1;
                len        = int'($urandom_range(1, 3000));
            end
            repeat (len) step();
            total += len;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
